// File: rtl/t_junction_phase_scheduler.sv
// Demand-actuated round-robin phase scheduler for the T-junction signal heads.
// Define PED_CROSS_EN to add the pedestrian walk phase (ped_req / walk ports).
module t_junction_phase_scheduler #(
  parameter int CNT_W       = 4,
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_GREEN = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             veh_M,
  input  logic             veh_MT,
  input  logic             veh_S,
`ifdef PED_CROSS_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic [2:0]       light_M1,
  output logic [2:0]       light_M2,
  output logic [2:0]       light_MT,
  output logic [2:0]       light_S,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       ps,
  output logic [1:0]       phase
);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_WALK   = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    PW = 2'd3
  } phase_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

`ifdef PED_CROSS_EN
  localparam int N_PHASES = 4;
`else
  localparam int N_PHASES = 3;
`endif

  localparam logic [CNT_W-1:0] C_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] C_WALK   = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] C_MING   = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] C_MAXG   = CNT_W'(T_MAX_GREEN - 1);

  state_t           r_state;
  phase_t           r_phase;
  logic [CNT_W-1:0] r_count;
  logic             r_demMT;
  logic             r_demS;
  logic             r_fresh;
  logic [2:0]       r_lightM1;
  logic [2:0]       r_lightM2;
  logic [2:0]       r_lightMT;
  logic [2:0]       r_lightS;

  state_t           w_nextState;
  phase_t           w_nextPhase;
  phase_t           w_rrPhase;
  logic [3:0]       w_pending;
  logic             w_demP;
  logic             w_ownSensor;
  logic             w_otherDemand;
  logic             w_greenExit;
  logic             w_enterService;
  logic             w_demMTNext;
  logic             w_demSNext;
  logic [CNT_W-1:0] w_countNext;
  logic [2:0]       w_head;
  logic [2:0]       w_lightM1Next;
  logic [2:0]       w_lightM2Next;
  logic [2:0]       w_lightMTNext;
  logic [2:0]       w_lightSNext;

`ifdef PED_CROSS_EN
  logic r_demP;
  logic r_walk;
  logic w_demPNext;
  assign w_demP = r_demP;
  assign walk   = r_walk;
`else
  assign w_demP = 1'b0;
`endif

  // First phase after cur (in round-robin order) with pending demand; P0 is always pending.
  function automatic phase_t rrNext(input phase_t cur, input logic [3:0] pend);
    phase_t     sel;
    logic [1:0] idx;
    sel = P0;
    for (int k = N_PHASES; k >= 1; k--) begin
      idx = 2'((int'(cur) + k) % N_PHASES);
      if (pend[idx]) sel = phase_t'(idx);
    end
    return sel;
  endfunction

  assign w_pending = {w_demP, r_demS, r_demMT, 1'b1};
  assign w_rrPhase = r_fresh ? P0 : rrNext(r_phase, w_pending);

  always_comb begin
    w_ownSensor = 1'b0;
    case (r_phase)
      P0:      w_ownSensor = veh_M;
      P1:      w_ownSensor = veh_MT;
      P2:      w_ownSensor = veh_S;
      default: w_ownSensor = 1'b0;
    endcase
  end

  assign w_otherDemand = (r_phase == P0) ? (r_demMT | r_demS | w_demP) : 1'b1;
  assign w_greenExit   = (r_count >= C_MING) && w_otherDemand &&
                         (!w_ownSensor || (r_count == C_MAXG));

  always_comb begin
    w_nextState = r_state;
    w_nextPhase = r_phase;
    case (r_state)
      S_ALLRED: begin
        if (r_count == C_ALLRED) begin
          w_nextPhase = w_rrPhase;
          w_nextState = (w_rrPhase == PW) ? S_WALK : S_GREEN;
        end
      end
      S_GREEN:  if (w_greenExit) w_nextState = S_YELLOW;
      S_YELLOW: if (r_count == C_YELLOW) w_nextState = S_ALLRED;
      S_WALK:   if (r_count == C_WALK) w_nextState = S_ALLRED;
      default:  w_nextState = S_ALLRED;
    endcase
  end

  assign w_enterService = (r_state == S_ALLRED) && (w_nextState != S_ALLRED);

  // A latch ignores its own sensor while served; clearing on service entry beats a same-edge set.
  always_comb begin
    w_demMTNext = r_demMT | (veh_MT && !(r_state == S_GREEN && r_phase == P1));
    w_demSNext  = r_demS  | (veh_S  && !(r_state == S_GREEN && r_phase == P2));
    if (w_enterService && w_nextPhase == P1) w_demMTNext = 1'b0;
    if (w_enterService && w_nextPhase == P2) w_demSNext  = 1'b0;
  end

`ifdef PED_CROSS_EN
  always_comb begin
    w_demPNext = r_demP | (ped_req && (r_state != S_WALK));
    if (w_enterService && w_nextPhase == PW) w_demPNext = 1'b0;
  end
`endif

  always_comb begin
    if (w_nextState != r_state) begin
      w_countNext = '0;
    end else if (r_state == S_GREEN && r_count == C_MAXG) begin
      w_countNext = r_count;
    end else begin
      w_countNext = r_count + 1'b1;
    end
  end

  // Head colours are computed for the state being entered so they register with ps.
  always_comb begin
    w_lightM1Next = RED;
    w_lightM2Next = RED;
    w_lightMTNext = RED;
    w_lightSNext  = RED;
    w_head        = (w_nextState == S_GREEN) ? GRN : YEL;
    if (w_nextState == S_GREEN || w_nextState == S_YELLOW) begin
      case (w_nextPhase)
        P0: begin
          w_lightM1Next = w_head;
          w_lightM2Next = w_head;
        end
        P1: begin
          w_lightM1Next = w_head;
          w_lightMTNext = w_head;
        end
        P2:      w_lightSNext = w_head;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_ALLRED;
      r_phase   <= P0;
      r_count   <= '0;
      r_demMT   <= 1'b0;
      r_demS    <= 1'b0;
      r_fresh   <= 1'b1;
      r_lightM1 <= RED;
      r_lightM2 <= RED;
      r_lightMT <= RED;
      r_lightS  <= RED;
`ifdef PED_CROSS_EN
      r_demP    <= 1'b0;
      r_walk    <= 1'b0;
`endif
    end else begin
      r_state   <= w_nextState;
      r_phase   <= w_nextPhase;
      r_count   <= w_countNext;
      r_demMT   <= w_demMTNext;
      r_demS    <= w_demSNext;
      r_lightM1 <= w_lightM1Next;
      r_lightM2 <= w_lightM2Next;
      r_lightMT <= w_lightMTNext;
      r_lightS  <= w_lightSNext;
      if (w_nextState != S_ALLRED) r_fresh <= 1'b0;
`ifdef PED_CROSS_EN
      r_demP    <= w_demPNext;
      r_walk    <= (w_nextState == S_WALK);
`endif
    end
  end

  assign ps       = r_state;
  assign phase    = r_phase;
  assign count    = r_count;
  assign light_M1 = r_lightM1;
  assign light_M2 = r_lightM2;
  assign light_MT = r_lightMT;
  assign light_S  = r_lightS;

endmodule
